if_fetch_ctrl: RTL and testbench
================================

Name: if_fetch_ctrl

Overview:
- Instruction-fetch sequencer for the five-stage pipeline. Owns the PC, drives the combinational instruction ROM's chip-enable and address, and buffers fetched words in a 2-entry queue toward IF/ID.
- Decouples decode back-pressure and branch redirects from ROM access. Replaces the bare pc_reg + IF/ID handoff.

Parameters:
- ADDR_W, 32, PC / ROM address width (matches `InstAddrBus)
- INST_W, 32, instruction width (matches `InstBus)
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous assert, active-high
- stall_i  in  1  pipeline-control freeze of fetch; no new ROM access while high
- branch_flag_i  in  1  redirect request from ID/EX, single-cycle pulse
- branch_target_i  in  ADDR_W  redirect address
- rom_ce_o  out  1  ROM chip enable (`ChipEnable = 1)
- rom_addr_o  out  ADDR_W  ROM byte address (= current PC)
- rom_inst_i  in  INST_W  ROM data, valid same cycle as addr when ce=1
- if_valid_o  out  1  queue head holds a valid instruction
- if_pc_o  out  ADDR_W  PC of head entry
- if_inst_o  out  INST_W  instruction of head entry
- id_ready_i  in  1  decode accepts head this cycle

Behaviour:
- Reset, asynchronous, while rst=1:
  - state=S_RST, pc=RESET_PC, queue count=0.
  - rom_ce_o=0, rom_addr_o=RESET_PC, if_valid_o=0, if_pc_o=0, if_inst_o=`ZeroWord.
- FSM:
  - S_RST: one cycle after rst falls, ce=0, then goes to S_FETCH.
  - S_FETCH: normal operation.
  - S_HOLD: entered when stall_i=1; ce=0, pc frozen; returns to S_FETCH on the first cycle stall_i=0.
  - rst in any state returns to S_RST immediately.
- Outputs:
  - rom_addr_o = pc at all times.
  - rom_ce_o = (state==S_FETCH) && !stall_i && !branch_flag_i && (count<2).
- push = rom_ce_o. At the clock edge, {pc, rom_inst_i} is written to the queue tail and pc <= pc+4, wrapping modulo 2^ADDR_W.
- pop = if_valid_o && id_ready_i; the head is removed at the edge. if_valid_o = (count!=0). if_pc_o/if_inst_o come from the head register; they are 0/`ZeroWord when empty.
- Simultaneous push and pop: count is unchanged and ordering is preserved. With count==1, one instruction per cycle is sustained.
- Full (count==2): ce=0, pc held. Pop in that cycle does not enable a push the same cycle (ce has no combinational path from id_ready_i).
- Empty: id_ready_i is ignored and no pop occurs.
- Branch (branch_flag_i=1): takes priority over stall, push and pop.
  - At the edge: queue flushed to count=0, pc <= {branch_target_i[ADDR_W-1:2], 2'b00} (misaligned low bits dropped).
  - That cycle rom_ce_o=0 and if_valid_o still shows the current head, but no pop is counted.
  - Branch while in S_HOLD loads pc, and state stays S_HOLD.
- Latency:
  - rst falls at edge E0: first ce=1 in the cycle after E1; if_valid_o rises after E2.
  - Redirect at edge B: first target fetch in cycle after B, target visible on if_*_o after B+1.
- stall_i high does not clear the queue; buffered entries may still be popped.

Decomposition:
- Add to defines.v: `FetchRstPc (RESET_PC default), `FetchQDepth=2, FSM state encodings `IfStRst/`IfStFetch/`IfStHold (2-bit).
- Reuse existing `InstAddrBus, `InstBus, `ChipEnable/`ChipDisable, `ZeroWord.
- One sub-module: if_queue2, a 2-entry FIFO of {pc,inst}.
  - Ports: push, pop, flush, count, head.
  - Flush dominates push/pop.
- The FSM and pc register live in if_fetch_ctrl.

Test Plan:
- Reset release, id_ready_i=1, ROM words k*0x11111111 at index k.
  - Required: ce=0 one cycle, then addrs 0x0,0x4,0x8.
  - Required: if_pc_o 0x0,0x4,0x8 on consecutive cycles from E0+2, if_inst_o 0x00000000,0x11111111,0x22222222.
- id_ready_i=0 from cycle of first valid.
  - Required: queue fills (pc 0x0,0x4), ce drops, rom_addr_o holds 0x8.
  - On id_ready_i=1: pops 0x0 then 0x4, no gaps, 0x8 follows.
- Queue holding 0x8,0xC, branch_flag_i=1, target 0x41.
  - Required: next edge count=0, pc=0x40; next cycle ce=1 addr 0x40; if_pc_o=0x40 one cycle later; 0x8/0xC never popped.
- stall_i=1 for 3 cycles with count=1, id_ready_i=1.
  - Required: entry popped, ce=0 for 3 cycles, pc unchanged.
  - Required: fetch resumes at the same pc the cycle after stall_i falls.
- pc=0xFFFFFFFC, continuous fetch.
  - Required: next address 0x00000000 (wrap), if_pc_o sequence ...FFFC, 00000000.
- rst asserted mid-stream with count=2.
  - Required: immediately if_valid_o=0, ce=0, rom_addr_o=RESET_PC.
  - Required: after release, identical sequence to scenario 1.

Source files
------------

// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer.
//   FETCH_RST_PC  - default first fetch address after reset
//   FETCH_Q_DEPTH - entries in the fetch -> decode queue
//   CHIP_ENABLE / CHIP_DISABLE - ROM chip-enable levels
//   if_state_e    - fetch FSM state encoding (2-bit)
package if_fetch_ctrl_pkg;

  localparam logic [31:0] FETCH_RST_PC  = 32'h0000_0000;
  localparam int          FETCH_Q_DEPTH = 2;

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

  typedef enum logic [1:0] {
    S_RST   = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } if_state_e;

endpackage

// File: rtl/if_queue2.sv
// Two-entry FIFO of fetched {pc, inst} words.
//   clk, rst - clock, async active-high reset
//   push     - write din at the tail (ignored when full and not popping)
//   pop      - remove the head (ignored when empty)
//   flush    - empty the queue; dominates push and pop
//   din      - entry to write
//   count    - number of valid entries (0..2)
//   head     - oldest entry, all zeros when empty
module if_queue2
  import if_fetch_ctrl_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [1:0]   count,
  output logic [W-1:0] head
);

  logic [W-1:0] q0, q1;  // q0 is always the head
  logic [1:0]   cnt;
  logic         do_pop, do_push;

  assign do_pop  = pop && (cnt != 2'd0);
  // A full queue only takes a new word when it also drains one.
  assign do_push = push && ((cnt < 2'(FETCH_Q_DEPTH)) || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 2'd0;
      q0  <= '0;
      q1  <= '0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (cnt == 2'd0) q0 <= din;
          else             q1 <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          q0  <= q1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          // Count unchanged; shift so the older word stays ahead.
          if (cnt == 2'd1) begin
            q0 <= din;
          end else begin
            q0 <= q1;
            q1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign count = cnt;
  assign head  = (cnt != 2'd0) ? q0 : '0;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the combinational ROM,
// and buffers fetched words in a 2-entry queue toward decode.
//   clk, rst          - clock, async active-high reset
//   stall_i           - freeze fetch (no ROM access)
//   branch_flag_i     - redirect pulse; branch_target_i is the new PC
//   rom_ce_o/addr_o   - ROM chip enable / byte address (= PC)
//   rom_inst_i        - ROM data, same cycle as address
//   if_valid_o/pc_o/inst_o - queue head toward decode
//   id_ready_i        - decode takes the head this cycle
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RST_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [INST_W-1:0] rom_inst_i,
  output logic              if_valid_o,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [INST_W-1:0] if_inst_o,
  input  logic              id_ready_i
);

  if_state_e                state, state_nxt;
  logic [ADDR_W-1:0]        pc;
  logic [1:0]               q_count;
  logic [ADDR_W+INST_W-1:0] q_head;
  logic                     ce, pop;

  // Redirect targets are word aligned; the low bits are deliberately dropped.
  logic unused_tgt_lsb;
  assign unused_tgt_lsb = ^branch_target_i[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_RST;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ce        = CHIP_DISABLE;
    case (state)
      S_RST:   state_nxt = S_FETCH;
      S_FETCH: begin
        if (stall_i) state_nxt = S_HOLD;
        // No id_ready_i term: a pop never opens a slot for a same-cycle push.
        if (!stall_i && !branch_flag_i && (q_count < 2'(FETCH_Q_DEPTH)))
          ce = CHIP_ENABLE;
      end
      S_HOLD: begin
        // A redirect while held loads the PC but keeps the hold.
        if (!stall_i && !branch_flag_i) state_nxt = S_FETCH;
      end
      default: state_nxt = S_RST;
    endcase
  end

  // Branch wins over pop: the head is shown but not consumed.
  assign pop = (q_count != 2'd0) && id_ready_i && !branch_flag_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                pc <= RESET_PC;
    else if (branch_flag_i) pc <= {branch_target_i[ADDR_W-1:2], 2'b00};
    else if (ce)            pc <= pc + ADDR_W'(4);
  end

  if_queue2 #(.W(ADDR_W + INST_W)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (ce),
    .pop   (pop),
    .flush (branch_flag_i),
    .din   ({pc, rom_inst_i}),
    .count (q_count),
    .head  (q_head)
  );

  assign rom_ce_o   = ce;
  assign rom_addr_o = pc;
  assign if_valid_o = (q_count != 2'd0);
  assign if_pc_o    = q_head[ADDR_W+INST_W-1:INST_W];
  assign if_inst_o  = q_head[INST_W-1:0];

endmodule

// File: tb/tb_if_fetch_ctrl.sv
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_inst_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        id_ready_i = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // ROM model: word k holds k*0x11111111.
  assign rom_inst_i = 32'((rom_addr_o >> 2) * 32'h1111_1111);

  if_fetch_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .rom_ce_o        (rom_ce_o),
    .rom_addr_o      (rom_addr_o),
    .rom_inst_i      (rom_inst_i),
    .if_valid_o      (if_valid_o),
    .if_pc_o         (if_pc_o),
    .if_inst_o       (if_inst_o),
    .id_ready_i      (id_ready_i)
  );

  typedef struct {
    logic        rst, stall, br;
    logic [31:0] tgt;
    logic        rdy;
    logic        ce;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc, inst;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t v(logic r, logic s, logic b, logic [31:0] t, logic rd,
                             logic c, logic [31:0] a, logic vl, logic [31:0] p,
                             logic [31:0] i);
    vec_t x;
    x.rst = r; x.stall = s; x.br = b; x.tgt = t; x.rdy = rd;
    x.ce = c; x.addr = a; x.vld = vl; x.pc = p; x.inst = i;
    return x;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0d: got %08h expected %08h", name, idx, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //                 rst st br tgt            rdy ce addr          vld pc            inst
    vt.push_back(v(1, 0, 0, 32'h0,         0,  0, 32'h0,        0, 32'h0,        32'h0));        // 0 in reset
    vt.push_back(v(1, 0, 0, 32'h0,         1,  0, 32'h0,        0, 32'h0,        32'h0));
    vt.push_back(v(0, 0, 0, 32'h0,         1,  0, 32'h0,        0, 32'h0,        32'h0));        // S_RST cycle
    vt.push_back(v(0, 0, 0, 32'h0,         1,  1, 32'h0,        0, 32'h0,        32'h0));
    vt.push_back(v(0, 0, 0, 32'h0,         1,  1, 32'h4,        1, 32'h0,        32'h0));
    vt.push_back(v(0, 0, 0, 32'h0,         1,  1, 32'h8,        1, 32'h4,        32'h1111_1111));
    vt.push_back(v(0, 0, 0, 32'h0,         1,  1, 32'hC,        1, 32'h8,        32'h2222_2222));
    vt.push_back(v(1, 0, 0, 32'h0,         0,  0, 32'h0,        0, 32'h0,        32'h0));        // 7 back-pressure run
    vt.push_back(v(0, 0, 0, 32'h0,         0,  0, 32'h0,        0, 32'h0,        32'h0));
    vt.push_back(v(0, 0, 0, 32'h0,         0,  1, 32'h0,        0, 32'h0,        32'h0));
    vt.push_back(v(0, 0, 0, 32'h0,         0,  1, 32'h4,        1, 32'h0,        32'h0));
    vt.push_back(v(0, 0, 0, 32'h0,         0,  0, 32'h8,        1, 32'h0,        32'h0));        // full
    vt.push_back(v(0, 0, 0, 32'h0,         0,  0, 32'h8,        1, 32'h0,        32'h0));
    vt.push_back(v(0, 0, 0, 32'h0,         1,  0, 32'h8,        1, 32'h0,        32'h0));        // pop while full, no push
    vt.push_back(v(0, 0, 0, 32'h0,         1,  1, 32'h8,        1, 32'h4,        32'h1111_1111));
    vt.push_back(v(0, 0, 0, 32'h0,         0,  1, 32'hC,        1, 32'h8,        32'h2222_2222));
    vt.push_back(v(0, 0, 1, 32'h41,        1,  0, 32'h10,       1, 32'h8,        32'h2222_2222)); // 16 branch, queue {8,C}
    vt.push_back(v(0, 0, 0, 32'h0,         1,  1, 32'h40,       0, 32'h0,        32'h0));
    vt.push_back(v(0, 0, 0, 32'h0,         1,  1, 32'h44,       1, 32'h40,       32'h1111_1110));
    vt.push_back(v(0, 0, 0, 32'h0,         1,  1, 32'h48,       1, 32'h44,       32'h2222_2221));
    vt.push_back(v(0, 1, 0, 32'h0,         1,  0, 32'h4C,       1, 32'h48,       32'h3333_3332)); // 20 stall, pop
    vt.push_back(v(0, 1, 0, 32'h0,         1,  0, 32'h4C,       0, 32'h0,        32'h0));
    vt.push_back(v(0, 1, 0, 32'h0,         1,  0, 32'h4C,       0, 32'h0,        32'h0));
    vt.push_back(v(0, 0, 0, 32'h0,         1,  0, 32'h4C,       0, 32'h0,        32'h0));        // leaving hold
    vt.push_back(v(0, 0, 0, 32'h0,         1,  1, 32'h4C,       0, 32'h0,        32'h0));        // resume same pc
    vt.push_back(v(0, 0, 1, 32'hFFFF_FFFF, 1,  0, 32'h50,       1, 32'h4C,       32'h4444_4443)); // 25 branch to top
    vt.push_back(v(0, 0, 0, 32'h0,         1,  1, 32'hFFFF_FFFC, 0, 32'h0,       32'h0));
    vt.push_back(v(0, 0, 0, 32'h0,         1,  1, 32'h0,        1, 32'hFFFF_FFFC, 32'h2EEE_EEEF)); // wrap
    vt.push_back(v(0, 0, 0, 32'h0,         0,  1, 32'h4,        1, 32'h0,        32'h0));
    vt.push_back(v(0, 0, 0, 32'h0,         0,  0, 32'h8,        1, 32'h0,        32'h0));        // count=2
    vt.push_back(v(1, 0, 0, 32'h0,         1,  0, 32'h0,        0, 32'h0,        32'h0));        // 30 mid-stream reset
    vt.push_back(v(0, 0, 0, 32'h0,         1,  0, 32'h0,        0, 32'h0,        32'h0));
    vt.push_back(v(0, 0, 0, 32'h0,         1,  1, 32'h0,        0, 32'h0,        32'h0));
    vt.push_back(v(0, 0, 0, 32'h0,         1,  1, 32'h4,        1, 32'h0,        32'h0));
    vt.push_back(v(0, 0, 0, 32'h0,         1,  1, 32'h8,        1, 32'h4,        32'h1111_1111));
    vt.push_back(v(0, 0, 0, 32'h0,         1,  1, 32'hC,        1, 32'h8,        32'h2222_2222));

    for (int i = 0; i < vt.size(); i++) begin
      cyc();
      rst = vt[i].rst; stall_i = vt[i].stall; branch_flag_i = vt[i].br;
      branch_target_i = vt[i].tgt; id_ready_i = vt[i].rdy;
      @(negedge clk);
      chk("ce",    i, 32'(rom_ce_o),   32'(vt[i].ce));
      chk("addr",  i, rom_addr_o,      vt[i].addr);
      chk("valid", i, 32'(if_valid_o), 32'(vt[i].vld));
      chk("pc",    i, if_pc_o,         vt[i].pc);
      chk("inst",  i, if_inst_o,       vt[i].inst);
    end

    // Redirect while held: pc loads, fetch stays off until stall drops.
    cyc(); stall_i = 1; id_ready_i = 0; branch_flag_i = 0;
    @(negedge clk); chk("hold_ce0", 100, 32'(rom_ce_o), 32'd0);
    cyc(); branch_flag_i = 1; branch_target_i = 32'h0000_0203;
    @(negedge clk); chk("hold_br_ce", 101, 32'(rom_ce_o), 32'd0);
    cyc(); branch_flag_i = 0;
    @(negedge clk);
    chk("hold_br_ce2",   102, 32'(rom_ce_o),   32'd0);
    chk("hold_br_addr",  102, rom_addr_o,      32'h200);
    chk("hold_br_valid", 102, 32'(if_valid_o), 32'd0);
    cyc(); stall_i = 0; id_ready_i = 1;
    begin
      int n = 0;
      @(negedge clk);
      while (!rom_ce_o && n < 5) begin
        cyc(); @(negedge clk); n++;
      end
      chk("resume_ce",   103, 32'(rom_ce_o), 32'd1);
      chk("resume_addr", 103, rom_addr_o,    32'h200);
      n = 0;
      while (!if_valid_o && n < 5) begin
        cyc(); @(negedge clk); n++;
      end
      chk("resume_valid", 104, 32'(if_valid_o), 32'd1);
      chk("resume_pc",    104, if_pc_o,         32'h200);
      chk("resume_inst",  104, if_inst_o,       32'h8888_8880);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
